// File: rtl/proc_z_pkg.sv
// Shared definitions for the execute stage: instruction class codes, ALU
// function codes, the "no write" register index, condition-code bit
// positions, the reset value of the condition codes and the stage state type.
//
// Optional feature macro: EXEC_STAGE_MUL_EN adds the BUSY state used while
// the iterative multiplier runs.
package proc_z_pkg;

    localparam logic [3:0] ICODE_NOP   = 4'h0;
    localparam logic [3:0] ICODE_IRMOV = 4'h1;
    localparam logic [3:0] ICODE_OP    = 4'h2;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_XOR = 4'h3;
    localparam logic [3:0] ALU_MUL = 4'h4;

    localparam logic [3:0] REG_NONE = 4'hF;

    // Condition codes are packed as {ZF,SF,OF}.
    localparam int CC_ZF = 2;
    localparam int CC_SF = 1;
    localparam int CC_OF = 0;
    localparam logic [2:0] CC_RESET = 3'b100;

`ifdef EXEC_STAGE_MUL_EN
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd2
    } state_t;
`endif

    // Builds the condition-code vector from a result and its overflow flag.
    function automatic logic [2:0] makeCc(input logic [31:0] res, input logic ovf);
        logic [2:0] c;
        c        = 3'b000;
        c[CC_ZF] = (res == 32'd0);
        c[CC_SF] = res[31];
        c[CC_OF] = ovf;
        return c;
    endfunction

endpackage

// File: rtl/exec_stage_if.sv
// Handshake bundle between decode, the execute stage and write-back.
//   Upstream side : in_valid/in_ready plus icode, ifun, rB, valA, valB, valC.
//   Downstream    : out_valid/out_ready plus dstE, valE.
//   Status        : cc {ZF,SF,OF}, err (sticky illegal-instruction flag).
// modport slave is the execute stage; modport master is its environment.
interface exec_stage_if;

    logic        in_valid;
    logic        in_ready;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rB;
    logic [31:0] valA;
    logic [31:0] valB;
    logic [15:0] valC;

    logic        out_valid;
    logic        out_ready;
    logic [3:0]  dstE;
    logic [31:0] valE;
    logic [2:0]  cc;
    logic        err;

    modport master (
        output in_valid, icode, ifun, rB, valA, valB, valC, out_ready,
        input  in_ready, out_valid, dstE, valE, cc, err
    );

    modport slave (
        input  in_valid, icode, ifun, rB, valA, valB, valC, out_ready,
        output in_ready, out_valid, dstE, valE, cc, err
    );

endinterface

// File: rtl/exec_mul.sv
// Iterative shift-add 32x32 multiplier, one multiplier bit per cycle.
// Ports:
//   clock, reset  - rising-edge clock, synchronous active-high reset
//   start_i       - load operands and begin (ignored while busy)
//   a_i, b_i      - multiplicand / multiplier
//   done_o        - high in the last iteration cycle; product_o is valid then
//   product_o     - full 64-bit product (combinational view of the final sum)
// Only instantiated when EXEC_STAGE_MUL_EN is defined.
module exec_mul (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        done_o,
    output logic [63:0] product_o
);

    logic [63:0] mcand_q;
    logic [63:0] acc_q;
    logic [63:0] acc_d;
    logic [31:0] mplier_q;
    logic [4:0]  count_q;
    logic        busy_q;

    // Partial-product add for the current multiplier bit. On the 32nd
    // iteration this is the finished product, so the stage can capture it
    // on the same edge that ends the iteration.
    always_comb begin
        acc_d = acc_q + (mplier_q[0] ? mcand_q : 64'd0);
    end

    assign product_o = acc_d;
    assign done_o    = busy_q && (count_q == 5'd31);

    // Operand load on start, then 32 shift-add steps.
    always_ff @(posedge clock) begin
        if (reset) begin
            mcand_q  <= 64'd0;
            acc_q    <= 64'd0;
            mplier_q <= 32'd0;
            count_q  <= 5'd0;
            busy_q   <= 1'b0;
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            count_q  <= count_q + 5'd1;
            if (count_q == 5'd31) begin
                busy_q <= 1'b0;
            end
        end else if (start_i) begin
            mcand_q  <= {32'd0, a_i};
            acc_q    <= 64'd0;
            mplier_q <= b_i;
            count_q  <= 5'd0;
            busy_q   <= 1'b1;
        end
    end

endmodule

// File: rtl/exec_stage.sv
// Execute stage: one-entry pipeline register computing irmov and OP results
// for write-back, with condition codes and a sticky illegal-instruction flag.
// Ports:
//   clock, reset - rising-edge clock, synchronous active-high reset
//   bus          - exec_stage_if.slave (in/out handshakes, operands, dstE,
//                  valE, cc, err)
// Parameter ZEXT_VALC: 1 zero-extends valC, 0 sign-extends it.
// Macro EXEC_STAGE_MUL_EN: enables OP ifun 4 (multiply) via exec_mul; without
// it that encoding is treated as illegal.
module exec_stage
    import proc_z_pkg::*;
#(
    parameter int ZEXT_VALC = 1
) (
    input logic       clock,
    input logic       reset,
    exec_stage_if.slave bus
);

    state_t      state_q, state_d;
    logic [3:0]  dstE_q, dstE_d;
    logic [31:0] valE_q, valE_d;
    logic [2:0]  cc_q, cc_d;
    logic        err_q, err_d;

    logic        accept;
    logic        retire;
    logic        isNop;
    logic        isIrmov;
    logic        isAlu;
    logic [31:0] valCExt;
    logic [31:0] aluRes;
    logic        aluOvf;

`ifdef EXEC_STAGE_MUL_EN
    logic        isMul;
    logic        mulStart;
    logic        mulDone;
    logic [63:0] mulProduct;

    exec_mul u_mul (
        .clock     (clock),
        .reset     (reset),
        .start_i   (mulStart),
        .a_i       (bus.valA),
        .b_i       (bus.valB),
        .done_o    (mulDone),
        .product_o (mulProduct)
    );

    assign isMul = (bus.icode == ICODE_OP) && (bus.ifun == ALU_MUL);
`endif

    // A held result may retire in the same cycle a new instruction enters,
    // which keeps throughput at one per cycle.
    assign bus.in_ready  = (state_q == EMPTY) || ((state_q == FULL) && bus.out_ready);
    assign bus.out_valid = (state_q == FULL);
    assign accept        = bus.in_valid && bus.in_ready;
    assign retire        = bus.out_valid && bus.out_ready;

    assign bus.dstE = dstE_q;
    assign bus.valE = valE_q;
    assign bus.cc   = cc_q;
    assign bus.err  = err_q;

    assign valCExt = (ZEXT_VALC != 0) ? {16'd0, bus.valC} : {{16{bus.valC[15]}}, bus.valC};

    assign isNop   = (bus.icode == ICODE_NOP);
    assign isIrmov = (bus.icode == ICODE_IRMOV) && (bus.ifun == 4'h0);
    assign isAlu   = (bus.icode == ICODE_OP) &&
                     ((bus.ifun == ALU_ADD) || (bus.ifun == ALU_SUB) ||
                      (bus.ifun == ALU_AND) || (bus.ifun == ALU_XOR));

    // Single-cycle ALU. Overflow means both effective operands share a sign
    // that differs from the result's sign (for sub the effective second
    // operand is -valA, hence the inverted sign test).
    always_comb begin
        aluRes = 32'd0;
        aluOvf = 1'b0;
        case (bus.ifun)
            ALU_ADD: begin
                aluRes = bus.valB + bus.valA;
                aluOvf = (bus.valA[31] == bus.valB[31]) && (aluRes[31] != bus.valB[31]);
            end
            ALU_SUB: begin
                aluRes = bus.valB - bus.valA;
                aluOvf = (bus.valA[31] != bus.valB[31]) && (aluRes[31] != bus.valB[31]);
            end
            ALU_AND: aluRes = bus.valB & bus.valA;
            ALU_XOR: aluRes = bus.valB ^ bus.valA;
            default: begin
                aluRes = 32'd0;
                aluOvf = 1'b0;
            end
        endcase
    end

    // Next-state logic. Retirement empties the register first; an accepted
    // instruction then overrides that with its own outcome. nop and illegal
    // encodings are consumed and leave the stage EMPTY.
    always_comb begin
        state_d = state_q;
        dstE_d  = dstE_q;
        valE_d  = valE_q;
        cc_d    = cc_q;
        err_d   = err_q;
`ifdef EXEC_STAGE_MUL_EN
        mulStart = 1'b0;
`endif
        if (retire) begin
            state_d = EMPTY;
        end
        if (accept) begin
            if (isIrmov) begin
                state_d = FULL;
                dstE_d  = bus.rB;
                valE_d  = valCExt;
            end else if (isAlu) begin
                state_d = FULL;
                dstE_d  = bus.rB;
                valE_d  = aluRes;
                cc_d    = makeCc(aluRes, aluOvf);
`ifdef EXEC_STAGE_MUL_EN
            end else if (isMul) begin
                state_d  = BUSY;
                dstE_d   = bus.rB;
                mulStart = 1'b1;
`endif
            end else if (!isNop) begin
                state_d = EMPTY;
                err_d   = 1'b1;
            end else begin
                state_d = EMPTY;
            end
        end
`ifdef EXEC_STAGE_MUL_EN
        // Overflow for multiply flags any bits lost above the low word.
        if ((state_q == BUSY) && mulDone) begin
            state_d = FULL;
            valE_d  = mulProduct[31:0];
            cc_d    = makeCc(mulProduct[31:0], |mulProduct[63:32]);
        end
`endif
    end

    // State and result registers; reset drops any in-flight operation.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= EMPTY;
            dstE_q  <= REG_NONE;
            valE_q  <= 32'd0;
            cc_q    <= CC_RESET;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dstE_q  <= dstE_d;
            valE_q  <= valE_d;
            cc_q    <= cc_d;
            err_q   <= err_d;
        end
    end

endmodule
